// File: rtl/uart_echo_tester.sv
// Host-side loopback initiator. It sends a deterministic byte sequence through a UART transmitter,
// compares each echo from the receiver, and reports pass/fail together with an error count.
module uart_echo_tester #(
    parameter int unsigned NUM_BYTES      = 16,
    parameter logic [7:0]  START_BYTE     = 8'h41,
    parameter logic [7:0]  STEP           = 8'h01,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [7:0] tx_byte,
    output logic       tx_dv,
    input  logic       tx_ready,
    input  logic       rx_dv,
    input  logic [7:0] rx_byte,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [7:0] last_rx,
    output logic [1:0] state_out
);
    localparam int IDX_W = $clog2(NUM_BYTES + 1);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BYTES - 1);
    localparam logic [TMR_W-1:0] LAST_TICK = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        SEND      = 2'b01,
        WAIT_ECHO = 2'b10,
        DONE      = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [7:0]       cur_byte_q, cur_byte_d;
    logic [7:0]       tx_byte_d, err_d, last_rx_d;
    logic             tx_dv_d;
    logic             advance, bump_err;

    // NOTE: sequential state is updated only with non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            index_q    <= '0;
            timer_q    <= '0;
            cur_byte_q <= '0;
            tx_byte    <= '0;
            tx_dv      <= 1'b0;
            err_count  <= '0;
            last_rx    <= '0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            timer_q    <= timer_d;
            cur_byte_q <= cur_byte_d;
            tx_byte    <= tx_byte_d;
            tx_dv      <= tx_dv_d;
            err_count  <= err_d;
            last_rx    <= last_rx_d;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets its hold value first, so no path can infer a latch.
        state_d    = state_q;
        index_d    = index_q;
        timer_d    = timer_q;
        cur_byte_d = cur_byte_q;
        tx_byte_d  = tx_byte;
        tx_dv_d    = 1'b0;
        err_d      = err_count;
        last_rx_d  = last_rx;
        advance    = 1'b0;
        bump_err   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    err_d      = '0;
                    index_d    = '0;
                    cur_byte_d = START_BYTE;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = cur_byte_q;
                    timer_d   = '0;
                    state_d   = WAIT_ECHO;
                end
            end
            WAIT_ECHO: begin
                timer_d = timer_q + TMR_W'(1);
                // An echo landing in the timeout cycle still counts as a received byte.
                if (rx_dv) begin
                    last_rx_d = rx_byte;
                    bump_err  = (rx_byte != cur_byte_q);
                    advance   = 1'b1;
                end else if (timer_q == LAST_TICK) begin
                    bump_err = 1'b1;
                    advance  = 1'b1;
                end
            end
            default: ;
        endcase

        if (bump_err && err_count != 8'hFF) begin
            err_d = err_count + 8'd1;
        end

        if (advance) begin
            if (index_q == LAST_IDX) begin
                state_d = DONE;
            end else begin
                index_d    = index_q + IDX_W'(1);
                cur_byte_d = cur_byte_q + STEP;
                state_d    = SEND;
            end
        end
    end

    assign busy      = (state_q == SEND) || (state_q == WAIT_ECHO);
    assign done      = (state_q == DONE);
    assign pass      = (state_q == DONE) && (err_count == 8'd0);
    assign state_out = state_q;

endmodule

// File: tb/tb_uart_echo_tester.sv
// Directed bench for uart_echo_tester: a transmitter/echo model closes the loop around one instance,
// and a second instance starting at 8'hFE covers sequence wrap-around.
module tb_uart_echo_tester;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, tx_ready, rx_dv;
    logic [7:0] rx_byte;
    logic [7:0] tx_byte, err_count, last_rx;
    logic       tx_dv, busy, done, pass;
    logic [1:0] state_out;

    logic       start_b, tx_ready_b, rx_dv_b;
    logic [7:0] rx_byte_b;
    logic [7:0] tx_byte_b, err_count_b, last_rx_b;
    logic       tx_dv_b, busy_b, done_b, pass_b;
    logic [1:0] state_out_b;

    int checks   = 0;
    int failures = 0;

    // Loop-model controls, written only by the test sequence.
    logic       echo_en     = 1'b1;
    logic       bad_en      = 1'b0;
    logic       stray_en    = 1'b0;
    logic [7:0] bad_from    = 8'h00;
    logic [7:0] bad_to      = 8'h00;
    int         echo_delay  = 100;
    int         tx_busy_len = 8;

    // Loop-model observations, written only by the models.
    logic [7:0] sent_q[$];
    logic [7:0] sent_b_q[$];
    int         wait_q[$];
    int         wide_cnt    = 0;
    int         noready_cnt = 0;

    logic [7:0] seq_a[4] = '{8'h41, 8'h42, 8'h43, 8'h44};
    logic [7:0] seq_w[4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};

    uart_echo_tester #(
        .NUM_BYTES(4), .START_BYTE(8'h41), .STEP(8'h01), .TIMEOUT_CYCLES(200)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tx_byte(tx_byte), .tx_dv(tx_dv),
        .tx_ready(tx_ready), .rx_dv(rx_dv), .rx_byte(rx_byte), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count), .last_rx(last_rx), .state_out(state_out)
    );

    uart_echo_tester #(
        .NUM_BYTES(4), .START_BYTE(8'hFE), .STEP(8'h01), .TIMEOUT_CYCLES(50)
    ) dut_wrap (
        .clk(clk), .rst_n(rst_n), .start(start_b), .tx_byte(tx_byte_b), .tx_dv(tx_dv_b),
        .tx_ready(tx_ready_b), .rx_dv(rx_dv_b), .rx_byte(rx_byte_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .err_count(err_count_b), .last_rx(last_rx_b), .state_out(state_out_b)
    );

    initial forever #5 clk = ~clk;

    // Transmitter + loopback model: busy for tx_busy_len cycles after each strobe, echoes echo_delay
    // cycles after it, optionally corrupts one byte, optionally injects stray rx_dv outside WAIT_ECHO.
    initial begin : loop_model
        int         echo_cnt;
        int         busy_cnt;
        int         cur_wait;
        logic       prev_dv;
        logic [7:0] echo_val;
        echo_cnt = 0; busy_cnt = 0; cur_wait = 0; prev_dv = 1'b0; echo_val = 8'h00;
        tx_ready = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00;
        forever begin
            @(negedge clk);
            rx_dv = 1'b0;
            if (state_out == 2'b10) cur_wait++;
            else if (cur_wait != 0) begin
                wait_q.push_back(cur_wait);
                cur_wait = 0;
            end
            if (tx_dv) begin
                if (prev_dv) wide_cnt++;
                else sent_q.push_back(tx_byte);
                if (!tx_ready) noready_cnt++;
                echo_cnt = echo_delay;
                echo_val = (bad_en && tx_byte == bad_from) ? bad_to : tx_byte;
                busy_cnt = tx_busy_len;
                tx_ready = (tx_busy_len == 0);
            end else begin
                if (echo_cnt > 0) begin
                    echo_cnt--;
                    if (echo_cnt == 0 && echo_en) begin
                        rx_dv   = 1'b1;
                        rx_byte = echo_val;
                    end
                end
                if (busy_cnt > 0) begin
                    busy_cnt--;
                    if (busy_cnt == 0) tx_ready = 1'b1;
                end
                if (stray_en && state_out != 2'b10) begin
                    rx_dv   = 1'b1;
                    rx_byte = 8'hEE;
                end
            end
            prev_dv = tx_dv;
        end
    end

    // Always-ready transmitter with a 5-cycle echo for the wrap instance.
    initial begin : wrap_model
        int         echo_cnt;
        logic [7:0] echo_val;
        echo_cnt = 0; echo_val = 8'h00;
        tx_ready_b = 1'b1; rx_dv_b = 1'b0; rx_byte_b = 8'h00;
        forever begin
            @(negedge clk);
            rx_dv_b = 1'b0;
            if (tx_dv_b) begin
                sent_b_q.push_back(tx_byte_b);
                echo_cnt = 5;
                echo_val = tx_byte_b;
            end else if (echo_cnt > 0) begin
                echo_cnt--;
                if (echo_cnt == 0) begin
                    rx_dv_b   = 1'b1;
                    rx_byte_b = echo_val;
                end
            end
        end
    end

    // Called at a negedge; start is high across exactly one rising edge.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int k;
        k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s_done: done=%b after %0d cycles, required 1", name, done, budget);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({state_out, tx_dv, tx_byte, busy, done, pass, err_count, last_rx} !== 31'd0) begin
            failures++;
            $display("FAIL reset_outputs: state=%b tx_dv=%b tx_byte=%h busy=%b done=%b pass=%b err=%0d last_rx=%h, required all 0",
                     state_out, tx_dv, tx_byte, busy, done, pass, err_count, last_rx);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (state_out !== 2'b00 || sent_q.size() != 0) begin
            failures++;
            $display("FAIL idle_hold: state=%b sent=%0d, required state 00 and 0 bytes", state_out, sent_q.size());
        end
    endtask

    task automatic test_timeout();
        int n0, w0;
        echo_en = 1'b0; tx_busy_len = 5;
        n0 = sent_q.size(); w0 = wait_q.size();
        pulse_start();
        wait_done(3000, "timeout");
        checks++;
        if (err_count !== 8'd4 || pass !== 1'b0) begin
            failures++;
            $display("FAIL timeout_err: err=%0d pass=%b, required err=4 pass=0", err_count, pass);
        end
        checks++;
        if (last_rx !== 8'h00) begin
            failures++;
            $display("FAIL timeout_last_rx: last_rx=%h, required 00", last_rx);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (w0 + i >= wait_q.size()) begin
                failures++;
                $display("FAIL timeout_wait_len[%0d]: missing, required 200 cycles", i);
            end else if (wait_q[w0 + i] != 200) begin
                failures++;
                $display("FAIL timeout_wait_len[%0d]: %0d cycles, required 200", i, wait_q[w0 + i]);
            end
        end
        checks++;
        if (sent_q.size() - n0 != 4) begin
            failures++;
            $display("FAIL timeout_sent: %0d bytes, required 4", sent_q.size() - n0);
        end
        echo_en = 1'b1;
    endtask

    task automatic test_basic();
        int n0, wd0, nr0;
        echo_delay = 100; tx_busy_len = 150; bad_en = 1'b0;
        n0 = sent_q.size(); wd0 = wide_cnt; nr0 = noready_cnt;
        pulse_start();
        wait_done(3000, "basic");
        checks++;
        if (pass !== 1'b1 || err_count !== 8'd0 || busy !== 1'b0 || state_out !== 2'b11) begin
            failures++;
            $display("FAIL basic_status: pass=%b err=%0d busy=%b state=%b, required 1/0/0/11",
                     pass, err_count, busy, state_out);
        end
        checks++;
        if (last_rx !== 8'h44) begin
            failures++;
            $display("FAIL basic_last_rx: last_rx=%h, required 44", last_rx);
        end
        checks++;
        if (sent_q.size() - n0 != 4) begin
            failures++;
            $display("FAIL basic_sent: %0d bytes, required 4", sent_q.size() - n0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (sent_q[n0 + i] !== seq_a[i]) begin
                    failures++;
                    $display("FAIL basic_byte[%0d]: sent %h, required %h", i, sent_q[n0 + i], seq_a[i]);
                end
            end
        end
        checks++;
        if (wide_cnt != wd0 || noready_cnt != nr0) begin
            failures++;
            $display("FAIL basic_strobe: wide=%0d no_ready=%0d, required 0/0", wide_cnt - wd0, noready_cnt - nr0);
        end
    endtask

    task automatic test_mismatch();
        int n0;
        bad_en = 1'b1; bad_from = 8'h43; bad_to = 8'h63; tx_busy_len = 8;
        n0 = sent_q.size();
        pulse_start();
        wait_done(3000, "mismatch");
        checks++;
        if (err_count !== 8'd1 || pass !== 1'b0) begin
            failures++;
            $display("FAIL mismatch_err: err=%0d pass=%b, required err=1 pass=0", err_count, pass);
        end
        checks++;
        if (last_rx !== 8'h44) begin
            failures++;
            $display("FAIL mismatch_last_rx: last_rx=%h, required 44", last_rx);
        end
        checks++;
        if (sent_q.size() - n0 != 4) begin
            failures++;
            $display("FAIL mismatch_sent: %0d bytes, required 4", sent_q.size() - n0);
        end
        bad_en = 1'b0;
    endtask

    task automatic test_restart_clears();
        pulse_start();
        checks++;
        if (err_count !== 8'd0 || done !== 1'b0 || pass !== 1'b0 || state_out !== 2'b01) begin
            failures++;
            $display("FAIL restart_clear: err=%0d done=%b pass=%b state=%b, required 0/0/0/01",
                     err_count, done, pass, state_out);
        end
        wait_done(3000, "restart");
        checks++;
        if (pass !== 1'b1 || err_count !== 8'd0) begin
            failures++;
            $display("FAIL restart_result: pass=%b err=%0d, required pass=1 err=0", pass, err_count);
        end
    endtask

    task automatic test_corner();
        int n0, w0, k;
        echo_delay = 199; tx_busy_len = 250; stray_en = 1'b1;
        n0 = sent_q.size(); w0 = wait_q.size();
        pulse_start();
        k = 0;
        while (state_out !== 2'b10 && k < 600) begin
            @(negedge clk);
            k++;
        end
        pulse_start();
        checks++;
        if (state_out !== 2'b10 || busy !== 1'b1) begin
            failures++;
            $display("FAIL corner_start_in_wait: state=%b busy=%b, required 10/1", state_out, busy);
        end
        wait_done(5000, "corner");
        checks++;
        if (pass !== 1'b1 || err_count !== 8'd0 || last_rx !== 8'h44) begin
            failures++;
            $display("FAIL corner_result: pass=%b err=%0d last_rx=%h, required 1/0/44", pass, err_count, last_rx);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (w0 + i >= wait_q.size()) begin
                failures++;
                $display("FAIL corner_wait_len[%0d]: missing, required 200 cycles", i);
            end else if (wait_q[w0 + i] != 200) begin
                failures++;
                $display("FAIL corner_wait_len[%0d]: %0d cycles, required 200", i, wait_q[w0 + i]);
            end
        end
        checks++;
        if (sent_q.size() - n0 != 4) begin
            failures++;
            $display("FAIL corner_sent: %0d bytes, required 4", sent_q.size() - n0);
        end else if (sent_q[n0 + 1] !== seq_a[1]) begin
            failures++;
            $display("FAIL corner_sent: second byte %h, required %h", sent_q[n0 + 1], seq_a[1]);
        end
        stray_en = 1'b0; echo_delay = 100; tx_busy_len = 8;
    endtask

    task automatic test_wrap();
        int k;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        k = 0;
        while (done_b !== 1'b1 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (done_b !== 1'b1 || pass_b !== 1'b1 || err_count_b !== 8'd0 || last_rx_b !== 8'h01) begin
            failures++;
            $display("FAIL wrap_result: done=%b pass=%b err=%0d last_rx=%h, required 1/1/0/01",
                     done_b, pass_b, err_count_b, last_rx_b);
        end
        checks++;
        if (sent_b_q.size() != 4) begin
            failures++;
            $display("FAIL wrap_sent: %0d bytes, required 4", sent_b_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (sent_b_q[i] !== seq_w[i]) begin
                    failures++;
                    $display("FAIL wrap_byte[%0d]: sent %h, required %h", i, sent_b_q[i], seq_w[i]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int n0, n1, k;
        bad_en = 1'b1; bad_from = 8'h41; bad_to = 8'h5A;
        n0 = sent_q.size();
        pulse_start();
        k = 0;
        while (!(sent_q.size() - n0 == 2 && state_out === 2'b10) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        repeat (20) @(negedge clk);
        checks++;
        if (state_out !== 2'b10 || err_count !== 8'd1 || last_rx !== 8'h5A) begin
            failures++;
            $display("FAIL midreset_pre: state=%b err=%0d last_rx=%h, required 10/1/5A", state_out, err_count, last_rx);
        end
        echo_en = 1'b0; bad_en = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({state_out, tx_dv, tx_byte, busy, done, pass, err_count, last_rx} !== 31'd0) begin
            failures++;
            $display("FAIL midreset_async: state=%b tx_dv=%b tx_byte=%h busy=%b done=%b pass=%b err=%0d last_rx=%h, required all 0",
                     state_out, tx_dv, tx_byte, busy, done, pass, err_count, last_rx);
        end
        n1 = sent_q.size();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        checks++;
        if (sent_q.size() != n1 || state_out !== 2'b00) begin
            failures++;
            $display("FAIL midreset_quiet: %0d bytes sent state=%b, required 0 bytes state 00",
                     sent_q.size() - n1, state_out);
        end
        echo_en = 1'b1;
        pulse_start();
        wait_done(3000, "midreset_rerun");
        checks++;
        if (pass !== 1'b1 || err_count !== 8'd0 || last_rx !== 8'h44 || sent_q.size() - n1 != 4) begin
            failures++;
            $display("FAIL midreset_rerun: pass=%b err=%0d last_rx=%h sent=%0d, required 1/0/44/4",
                     pass, err_count, last_rx, sent_q.size() - n1);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start_b = 1'b0;
        test_reset();
        test_timeout();
        test_basic();
        test_mismatch();
        test_restart_clears();
        test_corner();
        test_wrap();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
